// File: rtl/ballot_pkg.sv
// ============================================================================
// Module   : ballot_pkg
// Purpose  : Shared widths, limits, FSM state encoding and helpers for the
//            ballot recorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ballot_pkg;

   localparam int NUM_CANDIDATES = 4;
   localparam int VOTE_W         = 8;
   localparam int TOTAL_W        = 10;
   localparam int CAND_IDX_W     = $clog2(NUM_CANDIDATES);
   localparam int CAND_CNT_W     = $clog2(NUM_CANDIDATES + 1);

   localparam logic [VOTE_W-1:0] VOTE_MAX = {VOTE_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_RECORD       = 2'd1,
      ST_WAIT_RELEASE = 2'd2,
      ST_LOCKOUT      = 2'd3
   } state_t;

   function automatic logic [CAND_CNT_W-1:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
      logic [CAND_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CANDIDATES; i++) begin
         n = n + CAND_CNT_W'(v[i]);
      end
      return n;
   endfunction

   // Lowest set bit wins; callers only use it on a one-hot vector.
   function automatic logic [CAND_IDX_W-1:0] onehot_index(input logic [NUM_CANDIDATES-1:0] v);
      logic [CAND_IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CANDIDATES - 1; i >= 0; i--) begin
         if (v[i]) idx = CAND_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Purpose  : Two-flop synchronizer followed by a stability counter; exposes
//            the accepted level and a one-cycle rise pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic level,
   output logic rise
);

   localparam int              c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;
   logic               r_rise;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= button;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_rise  <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;
   assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/ballot_recorder.sv
// ============================================================================
// Module   : ballot_recorder
// Purpose  : Four-candidate vote recorder with debounced buttons, multi-press
//            rejection, saturating tallies and a post-vote lockout.
//            Optional VOTE_TOTAL_EN adds a wrapping total_votes counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ballot_recorder
   import ballot_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LOCKOUT_CYCLES  = 100000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic              candidate1_button,
   input  logic              candidate2_button,
   input  logic              candidate3_button,
   input  logic              candidate4_button,
   output logic [VOTE_W-1:0] candidate1_vote,
   output logic [VOTE_W-1:0] candidate2_vote,
   output logic [VOTE_W-1:0] candidate3_vote,
   output logic [VOTE_W-1:0] candidate4_vote,
   output logic              valid_vote_casted,
   output logic              invalid_press
`ifdef VOTE_TOTAL_EN
   ,
   output logic [TOTAL_W-1:0] total_votes
`endif
);

   localparam int                  c_lock_w    = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCKOUT_CYCLES - 1);

   logic [NUM_CANDIDATES-1:0] w_buttons;
   logic [NUM_CANDIDATES-1:0] w_level;
   logic [NUM_CANDIDATES-1:0] w_rise;
   logic [CAND_CNT_W-1:0]     w_level_cnt;
   logic [CAND_CNT_W-1:0]     w_rise_cnt;

   state_t                    r_state;
   state_t                    w_next;
   logic                      w_capture;
   logic                      w_invalid;
   logic [CAND_IDX_W-1:0]     r_sel;
   logic [c_lock_w-1:0]       r_lock_cnt;
   logic [VOTE_W-1:0]         r_tally [NUM_CANDIDATES];

   assign w_buttons = {candidate4_button, candidate3_button, candidate2_button, candidate1_button};

   generate
      for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_debounce
         button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .button (w_buttons[g]),
            .level  (w_level[g]),
            .rise   (w_rise[g])
         );
      end
   endgenerate

   assign w_level_cnt = count_ones(w_level);
   assign w_rise_cnt  = count_ones(w_rise);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Rise pulses last one cycle, so edges seen outside IDLE are simply dropped.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_invalid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!mode && (w_rise_cnt != '0)) begin
               if ((w_rise_cnt == CAND_CNT_W'(1)) && (w_level_cnt == CAND_CNT_W'(1))) begin
                  w_next    = ST_RECORD;
                  w_capture = 1'b1;
               end else if (w_level_cnt > CAND_CNT_W'(1)) begin
                  w_next    = ST_WAIT_RELEASE;
                  w_invalid = 1'b1;
               end
            end
         end
         ST_RECORD: begin
            w_next = ST_WAIT_RELEASE;
         end
         ST_WAIT_RELEASE: begin
            if (w_level == '0) w_next = ST_LOCKOUT;
         end
         ST_LOCKOUT: begin
            if (r_lock_cnt == c_lock_last) w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sel      <= '0;
         r_lock_cnt <= '0;
      end else begin
         if (w_capture) r_sel <= onehot_index(w_rise);
         if ((w_next == ST_LOCKOUT) && (r_state != ST_LOCKOUT)) begin
            r_lock_cnt <= '0;
         end else if (r_state == ST_LOCKOUT) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CANDIDATES; i++) begin
            r_tally[i] <= '0;
         end
      end else if ((r_state == ST_RECORD) && (r_tally[r_sel] != VOTE_MAX)) begin
         r_tally[r_sel] <= r_tally[r_sel] + 1'b1;
      end
   end

`ifdef VOTE_TOTAL_EN
   logic [TOTAL_W-1:0] r_total;

   // Saturated votes still count here; wraps naturally at 2**TOTAL_W.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_total <= '0;
      end else if (r_state == ST_RECORD) begin
         r_total <= r_total + 1'b1;
      end
   end

   assign total_votes = r_total;
`endif

   assign candidate1_vote   = r_tally[0];
   assign candidate2_vote   = r_tally[1];
   assign candidate3_vote   = r_tally[2];
   assign candidate4_vote   = r_tally[3];
   assign valid_vote_casted = (r_state == ST_RECORD);
   assign invalid_press     = w_invalid;

endmodule

`default_nettype wire

// File: tb/tb_ballot_recorder.sv
// ============================================================================
// Module   : tb_ballot_recorder
// Purpose  : Directed self-checking bench for ballot_recorder (short debounce
//            and lockout); total_votes checks compile in with VOTE_TOTAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ballot_recorder;

   localparam int c_deb  = 4;
   localparam int c_lock = 8;

   logic       clock;
   logic       reset;
   logic       mode;
   logic [3:0] buttons;
   logic [7:0] candidate1_vote;
   logic [7:0] candidate2_vote;
   logic [7:0] candidate3_vote;
   logic [7:0] candidate4_vote;
   logic       valid_vote_casted;
   logic       invalid_press;
`ifdef VOTE_TOTAL_EN
   logic [9:0] total_votes;
`endif

   int n_checks;
   int n_fail;
   int valid_seen;
   int invalid_seen;

   ballot_recorder #(
      .DEBOUNCE_CYCLES (c_deb),
      .LOCKOUT_CYCLES  (c_lock)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .mode              (mode),
      .candidate1_button (buttons[0]),
      .candidate2_button (buttons[1]),
      .candidate3_button (buttons[2]),
      .candidate4_button (buttons[3]),
      .candidate1_vote   (candidate1_vote),
      .candidate2_vote   (candidate2_vote),
      .candidate3_vote   (candidate3_vote),
      .candidate4_vote   (candidate4_vote),
      .valid_vote_casted (valid_vote_casted),
      .invalid_press     (invalid_press)
`ifdef VOTE_TOTAL_EN
      ,
      .total_votes       (total_votes)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(negedge clock) begin
      if (valid_vote_casted) valid_seen++;
      if (invalid_press)     invalid_seen++;
   end

   task automatic check(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic vote(input int idx, input int hold);
      buttons[idx] = 1'b1;
      repeat (hold) @(negedge clock);
      buttons[idx] = 1'b0;
      repeat (20) @(negedge clock);
   endtask

   initial begin
      int v0;
      int i0;
      int lat;
`ifdef VOTE_TOTAL_EN
      int t0;
`endif
      n_checks     = 0;
      n_fail       = 0;
      valid_seen   = 0;
      invalid_seen = 0;
      reset        = 1'b1;
      mode         = 1'b0;
      buttons      = 4'b0000;
      repeat (3) @(negedge clock);

      check("reset_c1", candidate1_vote, 0);
      check("reset_c2", candidate2_vote, 0);
      check("reset_c3", candidate3_vote, 0);
      check("reset_c4", candidate4_vote, 0);
      check("reset_valid", valid_vote_casted, 0);
      check("reset_invalid", invalid_press, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Single clean vote for candidate 2
      v0 = valid_seen;
      vote(1, 20);
      check("c2_after_vote", candidate2_vote, 1);
      check("c2_valid_pulses", valid_seen - v0, 1);
      check("c2_c1_untouched", candidate1_vote, 0);
      check("c2_c3_untouched", candidate3_vote, 0);
      check("c2_c4_untouched", candidate4_vote, 0);

      // Two buttons together are rejected
      v0 = valid_seen;
      i0 = invalid_seen;
      buttons = 4'b0101;
      repeat (20) @(negedge clock);
      buttons = 4'b0000;
      repeat (20) @(negedge clock);
      check("multi_invalid_pulses", invalid_seen - i0, 1);
      check("multi_valid_pulses", valid_seen - v0, 0);
      check("multi_c1", candidate1_vote, 0);
      check("multi_c3", candidate3_vote, 0);

      // Re-press during post-vote window is discarded
      v0 = valid_seen;
      buttons[3] = 1'b1;
      repeat (12) @(negedge clock);
      buttons[3] = 1'b0;
      repeat (3) @(negedge clock);
      vote(3, 12);
      check("lock_c4_ignored", candidate4_vote, 1);
      check("lock_valid_pulses", valid_seen - v0, 1);
      vote(3, 12);
      check("lock_c4_second", candidate4_vote, 2);

      // Glitch, then press in result mode
      v0 = valid_seen;
      buttons[2] = 1'b1;
      repeat (2) @(negedge clock);
      buttons[2] = 1'b0;
      repeat (20) @(negedge clock);
      mode = 1'b1;
      vote(2, 20);
      mode = 1'b0;
      repeat (5) @(negedge clock);
      check("glitch_mode_c3", candidate3_vote, 0);
      check("glitch_mode_valid", valid_seen - v0, 0);

      // Saturation on candidate 1
      v0 = valid_seen;
`ifdef VOTE_TOTAL_EN
      t0 = int'(total_votes);
`endif
      for (int n = 0; n < 255; n++) vote(0, 12);
      check("sat_c1_at_255", candidate1_vote, 255);
      for (int n = 0; n < 5; n++) vote(0, 12);
      check("sat_c1_held", candidate1_vote, 255);
      check("sat_valid_pulses", valid_seen - v0, 260);
`ifdef VOTE_TOTAL_EN
      check("sat_total", (int'(total_votes) - t0 + 1024) % 1024, 260);
`endif

      // Async reset mid-lockout, with candidate 1 held through release
      buttons[0] = 1'b1;
      repeat (12) @(negedge clock);
      buttons[0] = 1'b0;
      repeat (10) @(negedge clock);
      check("pre_reset_c1", candidate1_vote, 255);
      check("pre_reset_c2", candidate2_vote, 1);
      buttons[0] = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("async_c1", candidate1_vote, 0);
      check("async_c2", candidate2_vote, 0);
      check("async_c4", candidate4_vote, 0);
      check("async_valid", valid_vote_casted, 0);
      check("async_invalid", invalid_press, 0);
`ifdef VOTE_TOTAL_EN
      check("async_total", total_votes, 0);
`endif
      repeat (3) @(negedge clock);
      reset = 1'b0;
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clock);
         #1;
         if (valid_vote_casted) begin
            lat = k;
            break;
         end
      end
      check("held_reset_latency", lat, c_deb + 3);
      buttons[0] = 1'b0;
      repeat (20) @(negedge clock);
      check("post_reset_c1", candidate1_vote, 1);
`ifdef VOTE_TOTAL_EN
      check("post_reset_total", total_votes, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ballot_recorder.md
BALLOT_RECORDER -- requirements
Module: ballot_recorder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000; consecutive stable synchronized cycles before a button level is accepted.
REQ-002 Parameter LOCKOUT_CYCLES, default 100000000; idle cycles enforced after a vote before the next is accepted.
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 mode  input  1  0 = voting, 1 = result; recording only when 0.
REQ-006 candidate1_button..candidate4_button  input  1 each  raw, asynchronous, active-high push buttons.
REQ-007 candidate1_vote..candidate4_vote  output  8 each  registered per-candidate vote tallies.
REQ-008 valid_vote_casted  output  1  one-cycle pulse per accepted vote.
REQ-009 invalid_press  output  1  one-cycle pulse when a press is rejected as multi-button.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-011 FSM states SHALL be IDLE, RECORD, WAIT_RELEASE, LOCKOUT.
- IDLE -> RECORD: mode==0 and exactly one debounced rising edge in a cycle, and no other debounced button currently high.
- IDLE -> WAIT_RELEASE: mode==0 and more than one debounced button high on an edge cycle; invalid_press pulses that cycle.
- RECORD -> WAIT_RELEASE: unconditional, after one cycle.
- WAIT_RELEASE -> LOCKOUT: all debounced levels low.
- LOCKOUT -> IDLE: after LOCKOUT_CYCLES cycles in LOCKOUT.
REQ-012 In RECORD the selected tally SHALL increment by 1 and valid_vote_casted SHALL be high for exactly that cycle; latency is 1 cycle from the debounced edge.
REQ-013 Tallies SHALL saturate at 255; a vote for a saturated candidate still pulses valid_vote_casted, but the tally holds.
REQ-014 With mode==1, edges in IDLE SHALL be ignored (no count, no pulse); a mode change in RECORD, WAIT_RELEASE or LOCKOUT SHALL NOT abort that state.
REQ-015 Edges arriving in RECORD, WAIT_RELEASE or LOCKOUT SHALL be discarded, never queued.
REQ-016 Lockout counter SHALL be sized to hold LOCKOUT_CYCLES and SHALL clear on entering LOCKOUT.

Reset
REQ-017 On reset assertion, immediately: tallies 0, valid_vote_casted 0, invalid_press 0, FSM IDLE, synchronizers, debounced levels and counters 0.
REQ-018 A button held across reset release SHALL produce a debounced edge DEBOUNCE_CYCLES+2 cycles after release.

Configuration
REQ-019 With VOTE_TOTAL_EN defined, output total_votes [9:0] SHALL count all accepted votes, including saturated ones, wrapping at 1023 and resetting to 0.
REQ-020 Without VOTE_TOTAL_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Package ballot_pkg SHALL hold NUM_CANDIDATES=4, VOTE_W=8, TOTAL_W=10, the FSM state enum and the saturation maximum.
REQ-022 Sub-module button_debouncer (synchronizer + debounce counter + registered level + rise pulse) SHALL be instantiated once per candidate.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-023 Press button2 for 20 cycles in mode 0 -> candidate2_vote 0->1, exactly one valid_vote_casted pulse, other tallies 0.
REQ-024 Press button1 and button3 together -> invalid_press one pulse, no tally change, no valid pulse.
REQ-025 Vote button4, release, press button4 again 3 cycles after release (inside lockout) -> ignored; press again after lockout -> candidate4_vote=2.
REQ-026 Apply 260 accepted votes to button1 -> candidate1_vote=255, 260 valid pulses, total_votes=260 with VOTE_TOTAL_EN.
REQ-027 Press button3 with a 2-cycle glitch, then with mode=1 held for 20 cycles -> no count, no pulse.
REQ-028 Assert reset asynchronously mid-LOCKOUT with tallies nonzero -> all outputs 0 before next clock edge; FSM IDLE after release.
